// File: rtl/int_to_float_serial.sv
// Serial two's-complement integer to {sign, exp, mag} float converter; normalizes one bit per cycle.
// Optional build macro ROUND_NEAREST_EN selects round-half-up instead of truncation of the dropped bits.
module int_to_float_serial #(
    parameter int IN_W  = 12,
    parameter int MAG_W = 8,
    parameter int EXP_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_int,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAG_W:0]   out_float,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   sign_q;
    logic [IN_W-1:0]        abs_q;
    logic [EXP_W-1:0]       exp_q;
    logic                   out_valid_q;
    logic [EXP_W+MAG_W:0]   out_float_q;

    logic [IN_W-1:0]        abs_in_d;
    logic [MAG_W-1:0]       mag_d;
    logic [EXP_W-1:0]       exp_d;

    // The most negative input maps to 100..0, which is still exact as an unsigned magnitude.
    always_comb begin
        abs_in_d = in_int[IN_W-1] ? (~in_int + IN_W'(1)) : in_int;
    end

`ifdef ROUND_NEAREST_EN
    logic             rnd_bit;
    logic [MAG_W:0]   mag_sum_d;

    function automatic logic [MAG_W:0] round_half_up(input logic [MAG_W-1:0] mag,
                                                     input logic             rnd);
        return {1'b0, mag} + {{MAG_W{1'b0}}, rnd};
    endfunction

    if (IN_W > MAG_W) begin : g_rnd
        assign rnd_bit = abs_q[IN_W-MAG_W-1];
    end else begin : g_no_rnd
        assign rnd_bit = 1'b0;
    end

    // A carry out of the magnitude renormalizes to 100..0 with one more exponent step.
    always_comb begin
        mag_sum_d = round_half_up(abs_q[IN_W-1 -: MAG_W], rnd_bit);
        mag_d     = mag_sum_d[MAG_W-1:0];
        exp_d     = exp_q;
        if (mag_sum_d[MAG_W]) begin
            mag_d          = '0;
            mag_d[MAG_W-1] = 1'b1;
            exp_d          = exp_q + EXP_W'(1);
        end
    end
`else
    always_comb begin
        mag_d = abs_q[IN_W-1 -: MAG_W];
        exp_d = exp_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_float_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_int[IN_W-1];
                        abs_q  <= abs_in_d;
                        exp_q  <= EXP_W'(IN_W);
                        if (in_int == '0) begin
                            out_float_q <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (abs_q[IN_W-1]) begin
                        out_float_q <= {sign_q, exp_d, mag_d};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        abs_q <= abs_q << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign busy      = (state_q == NORM) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_float = out_float_q;

endmodule

// File: tb/tb_int_to_float_serial.sv
// Randomized self-checking bench for int_to_float_serial against a bit-length based reference model.
// Honors ROUND_NEAREST_EN the same way the design does.
module tb_int_to_float_serial;

    localparam int IN_W  = 12;
    localparam int MAG_W = 8;
    localparam int EXP_W = 4;
    localparam int OUT_W = 1 + EXP_W + MAG_W;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_int;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_float;
    logic             busy;

    int n_checks;
    int n_pass;

    int_to_float_serial #(
        .IN_W  (IN_W),
        .MAG_W (MAG_W),
        .EXP_W (EXP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input logic [IN_W-1:0] x);
        return x[IN_W-1] ? int'(x) - (1 << IN_W) : int'(x);
    endfunction

    function automatic int bit_len(input int a);
        int e;
        e = 0;
        while ((1 << e) <= a) e++;
        return e;
    endfunction

    // value = (-1)^s * m/2^MAG_W * 2^e with 2^(e-1) <= |v| < 2^e
    function automatic logic [OUT_W-1:0] model_float(input logic [IN_W-1:0] x);
        int v, a, e, m;
        logic s;
        logic [EXP_W-1:0] ee;
        logic [MAG_W-1:0] mm;
        v = to_signed(x);
        if (v == 0) return '0;
        s = (v < 0);
        a = s ? -v : v;
        e = bit_len(a);
`ifdef ROUND_NEAREST_EN
        m = ((a << (MAG_W + 1)) >> e);
        m = (m + 1) >> 1;
        if (m == (1 << MAG_W)) begin
            m = 1 << (MAG_W - 1);
            e = e + 1;
        end
`else
        m = (a << MAG_W) >> e;
`endif
        ee = EXP_W'(e);
        mm = MAG_W'(m);
        return {s, ee, mm};
    endfunction

    function automatic int model_lat(input logic [IN_W-1:0] x);
        int v, a;
        v = to_signed(x);
        if (v == 0) return 1;
        a = (v < 0) ? -v : v;
        return 2 + (IN_W - bit_len(a));
    endfunction

    // Drives one conversion starting at a negedge; noise toggles in_valid/in_int/out_ready while busy.
    task automatic do_conv(input logic [IN_W-1:0] x, input int hold, input bit noise,
                           output logic [OUT_W-1:0] f, output int lat,
                           output bit hold_ok, output bit rdy_after);
        in_int   = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = noise;
        in_int   = noise ? IN_W'($urandom) : x;
        lat      = 1;
        hold_ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < TIMEOUT) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
            out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            if (noise) in_int = IN_W'($urandom);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            lat       = -1;
            f         = 'x;
            rdy_after = 1'b0;
            in_valid  = 1'b0;
            return;
        end
        f = out_float;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (noise) in_int = IN_W'($urandom);
            if (out_float !== f || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        rdy_after = (in_ready === 1'b1) && (out_valid === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_valid_busy: got %b/%b want 0/0", out_valid, busy);
        else n_pass++;
        n_checks++;
        if (out_float !== '0) $display("FAIL reset_out_float: got %h want 0", out_float);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [IN_W-1:0] vec [5];
        int holds [5];
        logic [OUT_W-1:0] f;
        int lat;
        bit hok, rok;
        vec = '{12'h001, 12'h800, 12'h7FF, 12'h000, 12'hF9C};
        holds = '{0, 1, 0, 2, 5};
        for (int i = 0; i < 5; i++) begin
            do_conv(vec[i], holds[i], 1'b0, f, lat, hok, rok);
            n_checks++;
            if (lat !== model_lat(vec[i]))
                $display("FAIL dir_latency in=%h: got %0d want %0d", vec[i], lat, model_lat(vec[i]));
            else n_pass++;
            n_checks++;
            if (f !== model_float(vec[i]))
                $display("FAIL dir_float in=%h: got %h want %h", vec[i], f, model_float(vec[i]));
            else n_pass++;
            n_checks++;
            if (!hok || !rok) $display("FAIL dir_handshake in=%h: hold_ok=%b ready_after=%b want 1/1",
                                       vec[i], hok, rok);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignored();
        logic [OUT_W-1:0] f;
        int lat;
        bit hok, rok;
        logic [IN_W-1:0] x;
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 12'h001 : (i == 1) ? 12'h000 : IN_W'($urandom);
            do_conv(x, i, 1'b1, f, lat, hok, rok);
            n_checks++;
            if (f !== model_float(x) || lat !== model_lat(x))
                $display("FAIL busy_ignored in=%h: got %h lat %0d want %h lat %0d",
                         x, f, lat, model_float(x), model_lat(x));
            else n_pass++;
            n_checks++;
            if (!hok || !rok) $display("FAIL busy_ignored_hs in=%h: hold_ok=%b ready_after=%b want 1/1",
                                       x, hok, rok);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] f;
        int lat, len;
        bit hok, rok;
        logic [IN_W-1:0] x;
        for (int i = 0; i < 60; i++) begin
            len = $urandom_range(0, IN_W);
            x = (len == 0) ? '0 : IN_W'($urandom_range(0, (1 << len) - 1));
            if ($urandom_range(0, 1) == 1) x = IN_W'(-int'(x));
            do_conv(x, $urandom_range(0, 2), 1'($urandom_range(0, 1)), f, lat, hok, rok);
            n_checks++;
            if (f !== model_float(x) || lat !== model_lat(x) || !hok || !rok)
                $display("FAIL random in=%h: got %h lat %0d hs %b%b want %h lat %0d hs 11",
                         x, f, lat, hok, rok, model_float(x), model_lat(x));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] f;
        int lat;
        bit hok, rok;
        logic [IN_W-1:0] x;
        for (int i = 0; i < 6; i++) begin
            x = IN_W'($urandom);
            do_conv(x, 0, 1'b0, f, lat, hok, rok);
            n_checks++;
            if (f !== model_float(x) || lat !== model_lat(x) || !rok)
                $display("FAIL back_to_back in=%h: got %h lat %0d rdy %b want %h lat %0d rdy 1",
                         x, f, lat, rok, model_float(x), model_lat(x));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [OUT_W-1:0] f;
        int lat;
        bit hok, rok;
        logic [IN_W-1:0] starts [2];
        starts = '{12'h001, 12'h000};
        for (int i = 0; i < 2; i++) begin
            in_int   = starts[i];
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || out_float !== '0 || busy !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL reset_mid_%0d: got v=%b f=%h busy=%b rdy=%b want 0/0/0/0",
                         i, out_valid, out_float, busy, in_ready);
            else n_pass++;
            reset = 1'b0;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL reset_mid_ready_%0d: got %b want 1", i, in_ready);
            else n_pass++;
            @(negedge clk);
            do_conv(12'hF9C, 1, 1'b0, f, lat, hok, rok);
            n_checks++;
            if (f !== model_float(12'hF9C) || lat !== model_lat(12'hF9C) || !hok || !rok)
                $display("FAIL reset_mid_after_%0d: got %h lat %0d want %h lat %0d",
                         i, f, lat, model_float(12'hF9C), model_lat(12'hF9C));
            else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_int    = '0;
        test_reset();
        test_directed();
        test_busy_ignored();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
